// File: rtl/io_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the board I/O register port.
interface io_arbiter_if;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_a;
  logic [DW-1:0] m0_wd;
  logic [DW-1:0] m0_rd;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_a;
  logic [DW-1:0] m1_wd;
  logic [DW-1:0] m1_rd;
  logic          m1_ack;

  logic          io_we;
  logic [AW-1:0] io_a;
  logic [DW-1:0] io_wd;
  logic [DW-1:0] io_rd;

  logic [1:0]    gnt;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_a, m0_wd,
    output m0_rd, m0_ack,
    input  m1_req, m1_we, m1_a, m1_wd,
    output m1_rd, m1_ack,
    output io_we, io_a, io_wd,
    input  io_rd,
    output gnt, busy
  );

  // Requesters plus board I/O side.
  modport master (
    output m0_req, m0_we, m0_a, m0_wd,
    input  m0_rd, m0_ack,
    output m1_req, m1_we, m1_a, m1_wd,
    input  m1_rd, m1_ack,
    input  io_we, io_a, io_wd,
    output io_rd,
    input  gnt, busy
  );
endinterface

// File: rtl/io_arbiter.sv
// Two-master arbiter for the board I/O register port: fixed priority to M0 with
// an anti-starvation counter for M1, each grant run as a registered single beat.
module io_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  io_arbiter_if.slave  bus
);
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t          r_state, w_state;
  logic            r_owner, w_owner;   // 1 = M1 owns the transaction
  logic            r_io_we, w_io_we;
  logic [AW-1:0]   r_io_a,  w_io_a;
  logic [DW-1:0]   r_io_wd, w_io_wd;
  logic [DW-1:0]   r_m0_rd, w_m0_rd;
  logic [DW-1:0]   r_m1_rd, w_m1_rd;
  logic            r_m0_ack, w_m0_ack;
  logic            r_m1_ack, w_m1_ack;
  logic [1:0]      r_gnt,   w_gnt;
  logic            r_busy,  w_busy;
  logic [CW-1:0]   r_wait_cnt, w_wait_cnt;
  logic            w_m1_wins;

  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_io_we    = r_io_we;
    w_io_a     = r_io_a;
    w_io_wd    = r_io_wd;
    w_m0_rd    = r_m0_rd;
    w_m1_rd    = r_m1_rd;
    w_m0_ack   = 1'b0;
    w_m1_ack   = 1'b0;
    w_gnt      = r_gnt;
    w_busy     = r_busy;
    w_wait_cnt = r_wait_cnt;
    // M1 wins when alone, or when it has lost MAX_WAIT contended rounds.
    w_m1_wins  = bus.m1_req && (!bus.m0_req || (r_wait_cnt >= CW'(MAX_WAIT)));

    case (r_state)
      ST_IDLE: begin
        w_io_we = 1'b0;
        w_io_a  = '0;
        w_io_wd = '0;
        if (bus.m0_req || bus.m1_req) begin
          w_state = ST_ACCESS;
          w_owner = w_m1_wins;
          w_busy  = 1'b1;
          if (w_m1_wins) begin
            w_io_we    = bus.m1_we;
            w_io_a     = bus.m1_a;
            w_io_wd    = bus.m1_wd;
            w_gnt      = 2'b10;
            w_wait_cnt = '0;
          end else begin
            w_io_we = bus.m0_we;
            w_io_a  = bus.m0_a;
            w_io_wd = bus.m0_wd;
            w_gnt   = 2'b01;
            if (bus.m1_req && (r_wait_cnt != {CW{1'b1}})) begin
              w_wait_cnt = r_wait_cnt + CW'(1);
            end
          end
        end
      end
      ST_ACCESS: begin
        w_state = ST_RESP;
        if (!r_io_we) begin
          if (r_owner) w_m1_rd = bus.io_rd;
          else         w_m0_rd = bus.io_rd;
        end
        w_io_we  = 1'b0;
        w_io_a   = '0;
        w_io_wd  = '0;
        w_m0_ack = !r_owner;
        w_m1_ack = r_owner;
      end
      ST_RESP: begin
        w_state = ST_IDLE;
        w_gnt   = 2'b00;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = ST_IDLE;
        w_io_we = 1'b0;
        w_io_a  = '0;
        w_io_wd = '0;
        w_gnt   = 2'b00;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_io_we    <= 1'b0;
      r_io_a     <= '0;
      r_io_wd    <= '0;
      r_m0_rd    <= '0;
      r_m1_rd    <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_gnt      <= 2'b00;
      r_busy     <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_owner    <= w_owner;
      r_io_we    <= w_io_we;
      r_io_a     <= w_io_a;
      r_io_wd    <= w_io_wd;
      r_m0_rd    <= w_m0_rd;
      r_m1_rd    <= w_m1_rd;
      r_m0_ack   <= w_m0_ack;
      r_m1_ack   <= w_m1_ack;
      r_gnt      <= w_gnt;
      r_busy     <= w_busy;
      r_wait_cnt <= w_wait_cnt;
    end
  end

  assign bus.io_we  = r_io_we;
  assign bus.io_a   = r_io_a;
  assign bus.io_wd  = r_io_wd;
  assign bus.m0_rd  = r_m0_rd;
  assign bus.m1_rd  = r_m1_rd;
  assign bus.m0_ack = r_m0_ack;
  assign bus.m1_ack = r_m1_ack;
  assign bus.gnt    = r_gnt;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: directed scenarios plus random two-master
// traffic compared against a transaction-timeline reference model.
module tb_io_arbiter;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_arbiter_if bus ();

  io_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = access cycle, 2 = response cycle.
  int          m_phase;
  int          m_wait;
  int          m_owner;
  logic        m_we;
  logic [3:0]  m_a;
  logic [31:0] m_wd;
  logic [31:0] m_rd [2];

  task automatic model_reset();
    m_phase = 0;
    m_wait  = 0;
    m_owner = 0;
    m_we    = 1'b0;
    m_a     = 4'h0;
    m_wd    = 32'h0;
    m_rd[0] = 32'h0;
    m_rd[1] = 32'h0;
  endtask

  task automatic drive_m(input int idx, input logic req, input logic we,
                         input logic [3:0] a, input logic [31:0] wd);
    if (idx == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_a = a; bus.m0_wd = wd;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_a = a; bus.m1_wd = wd;
    end
  endtask

  // One clock: snapshot the inputs seen at the edge, advance the model, check every output.
  task automatic step();
    logic r0, r1, we0, we1;
    logic [3:0] a0, a1;
    logic [31:0] wd0, wd1, rd_s;
    logic [31:0] e_we, e_a, e_wd, e_gnt, e_busy, e_ack0, e_ack1;
    r0 = bus.m0_req; we0 = bus.m0_we; a0 = bus.m0_a; wd0 = bus.m0_wd;
    r1 = bus.m1_req; we1 = bus.m1_we; a1 = bus.m1_a; wd1 = bus.m1_wd;
    rd_s = bus.io_rd;
    @(posedge clk);
    #1;
    case (m_phase)
      0: if (r0 || r1) begin
        if (r0 && r1) begin
          if (m_wait >= int'(MAX_WAIT)) begin
            m_owner = 1; m_wait = 0;
          end else begin
            m_owner = 0; m_wait = (m_wait < 255) ? m_wait + 1 : 255;
          end
        end else if (r1) begin
          m_owner = 1; m_wait = 0;
        end else begin
          m_owner = 0;
        end
        m_we = (m_owner == 1) ? we1 : we0;
        m_a  = (m_owner == 1) ? a1  : a0;
        m_wd = (m_owner == 1) ? wd1 : wd0;
        m_phase = 1;
      end
      1: begin
        if (!m_we) m_rd[m_owner] = rd_s;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    e_we = 0; e_a = 0; e_wd = 0; e_gnt = 0; e_busy = 0; e_ack0 = 0; e_ack1 = 0;
    if (m_phase == 1) begin
      e_we = 32'(m_we); e_a = 32'(m_a); e_wd = m_wd;
    end
    if (m_phase != 0) begin
      e_gnt  = (m_owner == 1) ? 32'd2 : 32'd1;
      e_busy = 32'd1;
    end
    if (m_phase == 2) begin
      e_ack0 = (m_owner == 0) ? 32'd1 : 32'd0;
      e_ack1 = (m_owner == 1) ? 32'd1 : 32'd0;
    end
    chk("io_we",  32'(bus.io_we),  e_we);
    chk("io_a",   32'(bus.io_a),   e_a);
    chk("io_wd",  bus.io_wd,       e_wd);
    chk("gnt",    32'(bus.gnt),    e_gnt);
    chk("busy",   32'(bus.busy),   e_busy);
    chk("m0_ack", 32'(bus.m0_ack), e_ack0);
    chk("m1_ack", 32'(bus.m1_ack), e_ack1);
    chk("m0_rd",  bus.m0_rd,       m_rd[0]);
    chk("m1_rd",  bus.m1_rd,       m_rd[1]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        p_req [2];
  logic        p_we  [2];
  logic [3:0]  p_a   [2];
  logic [31:0] p_wd  [2];
  int          grants [$];
  int          m1_count;

  initial begin
    drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 4'h0, 32'h0);
    bus.io_rd = 32'h0;
    model_reset();

    // Reset then idle.
    do_reset();
    step();

    // M0 write A=0, WD=0xA5.
    drive_m(0, 1'b1, 1'b1, 4'h0, 32'h0000_00A5);
    step();
    chk("wr_io_wd", bus.io_wd, 32'h0000_00A5);
    chk("wr_io_we", 32'(bus.io_we), 32'd1);
    drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0);
    step();
    chk("wr_ack", 32'(bus.m0_ack), 32'd1);
    step();

    // M1 read A=1 with board returning 0x1F.
    bus.io_rd = 32'h0000_001F;
    drive_m(1, 1'b1, 1'b0, 4'h1, 32'h1234_5678);
    step();
    drive_m(1, 1'b0, 1'b0, 4'h0, 32'h0);
    step();
    chk("rd_m1_rd", bus.m1_rd, 32'h0000_001F);
    step();

    // Continuous contention: grant order must be M0 x4, M1, repeating.
    do_reset();
    drive_m(0, 1'b1, 1'b1, 4'h3, 32'hCAFE_0000);
    drive_m(1, 1'b1, 1'b0, 4'h7, 32'h0);
    grants.delete();
    for (int i = 0; i < 30; i++) begin
      bus.io_rd = $urandom;
      step();
      if (m_phase == 1) grants.push_back(int'(bus.gnt));
    end
    chk("contend_n", 32'(grants.size()), 32'd10);
    for (int i = 0; i < grants.size(); i++)
      chk("contend_gnt", 32'(grants[i]), ((i % 5) == 4) ? 32'd2 : 32'd1);
    drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 4'h0, 32'h0);
    repeat (3) step();

    // Reset during the access cycle of a write aborts it.
    drive_m(0, 1'b1, 1'b1, 4'h2, 32'hDEAD_BEEF);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_we",   32'(bus.io_we),  32'd0);
    chk("abort_busy", 32'(bus.busy),   32'd0);
    chk("abort_gnt",  32'(bus.gnt),    32'd0);
    drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    chk("abort_ack",  32'(bus.m0_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Early REQ drop during ACCESS still completes the write.
    drive_m(0, 1'b1, 1'b1, 4'h0, 32'h0000_0042);
    step();
    drive_m(0, 1'b0, 1'b1, 4'h0, 32'h0000_0042);
    step();
    chk("drop_ack", 32'(bus.m0_ack), 32'd1);
    step();

    // Random traffic: each master holds its request until its response cycle.
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_a[i] = 4'h0; p_wd[i] = 32'h0;
    end
    m1_count = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_req[i] && ($urandom_range(0, 2) != 0)) begin
          p_req[i] = 1'b1;
          p_we[i]  = 1'($urandom_range(0, 1));
          p_a[i]   = 4'($urandom_range(0, 15));
          p_wd[i]  = $urandom;
        end
        drive_m(i, p_req[i], p_we[i], p_a[i], p_wd[i]);
      end
      bus.io_rd = $urandom;
      step();
      if (m_phase == 2) begin
        p_req[m_owner] = 1'b0;
        if (m_owner == 1) m1_count++;
      end
    end
    chk("rand_m1_served", 32'(m1_count > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_arbiter.md
Name: io_arbiter

Overview:
- Shares the single board-I/O register port (WE/A/WD/RD) between two requesters.
  - M0: CPU data-side I/O path.
  - M1: debug/monitor master.
- Arbitration is fixed-priority to M0, with an anti-starvation counter that guarantees M1 service.
- Each granted access is sequenced as a registered single-beat transaction. The block sits between the bus masters and the board I/O block.

Parameters:
- MAX_WAIT, 4, number of consecutive arbitrations M1 may lose while requesting before it is forced to win (1..255).

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- M0_REQ  in  1  M0 access request, held until M0_ACK
- M0_WE  in  1  M0 write enable (0 = read)
- M0_A  in  4  M0 register address
- M0_WD  in  32  M0 write data
- M0_RD  out  32  M0 read data, valid while M0_ACK=1
- M0_ACK  out  1  M0 one-cycle completion pulse
- M1_REQ, M1_WE, M1_A, M1_WD, M1_RD, M1_ACK: same as the M0 ports, for M1
- IO_WE  out  1  write strobe to board I/O
- IO_A  out  4  address to board I/O
- IO_WD  out  32  write data to board I/O
- IO_RD  in  32  combinational read data from board I/O
- GNT  out  2  one-hot current owner (bit0 = M0, bit1 = M1), 0 when idle
- BUSY  out  1  high in ACCESS or RESP

Behaviour:
- Reset values (async on RESET_N=0):
  - State = IDLE.
  - All outputs 0: IO_WE, IO_A, IO_WD, Mx_RD, Mx_ACK, GNT, BUSY.
  - wait_cnt = 0.
- Reset mid-transaction aborts immediately. No ACK is issued, and IO_WE drops asynchronously.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On a clock edge with any REQ high, choose a winner, register the winner's A/WD/WE onto IO_A/IO_WD/IO_WE, set GNT, and go to ACCESS.
  - With no REQ, stay in IDLE and keep IO outputs at 0.
- Winner selection:
  - Only M0_REQ: M0.
  - Only M1_REQ: M1.
  - Both requesting and wait_cnt < MAX_WAIT: M0 wins, and wait_cnt increments, saturating at 255.
  - Both requesting and wait_cnt >= MAX_WAIT: M1 wins.
  - wait_cnt clears to 0 whenever M1 is granted.
  - wait_cnt is unchanged when M1 is not requesting.
- ACCESS (exactly 1 cycle):
  - IO bus holds the registered values, and IO_WE is high for writes only.
  - At the end of the cycle, IO_RD is captured into the owner's Mx_RD register on reads. On writes Mx_RD keeps its previous value.
  - IO_A/IO_WD/IO_WE are cleared to 0 on exit. Go to RESP.
- RESP (exactly 1 cycle):
  - Owner's Mx_ACK = 1; the other master's ACK stays 0.
  - Mx_RD is stable.
  - GNT is still the owner; it clears on exit to IDLE.
  - REQ is not sampled in RESP. A master must drop REQ or keep it high for a new access; a still-high REQ is re-arbitrated in IDLE.
- Latency:
  - REQ sampled at edge N.
  - IO access is during cycle N+1.
  - ACK and RD are valid in cycle N+2.
  - Maximum throughput is one access per 3 cycles.
- A master dropping REQ during ACCESS does not cancel the access. The write still occurs and ACK still pulses.
- Writes reach board I/O exactly once per grant, with IO_WE high for exactly 1 cycle.
- Address and data are passed through unmodified: no decoding, no width change.

Test Plan:
- Reset then idle: RESET_N=0 for 2 cycles, then 1 with no REQ → all outputs 0, BUSY=0, no IO_WE.
- M0 write: M0_REQ=1, WE=1, A=0, WD=0x000000A5 → IO_WE=1 with IO_A=0 and IO_WD=0xA5 one cycle after sampling; M0_ACK pulses the next cycle; GNT=01; M1_ACK stays 0.
- M1 read: M1_REQ=1, WE=0, A=1, IO_RD=0x0000001F during ACCESS → M1_RD=0x1F with M1_ACK=1 two cycles after the sampling edge; IO_WE stays 0.
- Contention and starvation (MAX_WAIT=4): M0 and M1 request continuously → grant order is M0, M0, M0, M0, M1, then repeats; wait_cnt returns to 0 after the M1 grant.
- Abort: assert RESET_N=0 during ACCESS of a write → IO_WE falls immediately, no ACK, state is IDLE after release.
- Early REQ drop: M0_REQ drops during ACCESS of a write to A=0 → write still happens with one IO_WE pulse, and M0_ACK still pulses once.
